// File: rtl/tdm_demux2.sv
// Two-channel bit-serial TDM receiver: rebuilds one parallel word per channel after each frame sync.
// Optional even-parity bit per slot when TDM_PARITY_EN is defined.
module tdm_demux2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             den,
    input  logic             sync,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic             v0,
    output logic             v1,
    output logic             ferr,
    output logic             perr
);

`ifdef TDM_PARITY_EN
    localparam int SLOT = WIDTH + 1;
`else
    localparam int SLOT = WIDTH;
`endif
    localparam int CW = $clog2(SLOT + 1);
    localparam logic [CW-1:0] LAST = CW'(SLOT - 1);

    typedef enum logic [1:0] {
        IDLE,
        CH0,
        CH1
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cntNext;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shiftNext;
    logic [WIDTH-1:0] w_shiftIn;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_o0;
    logic [WIDTH-1:0] r_o1;
    logic             r_v0;
    logic             r_v1;
    logic             r_ferr;
    logic             w_load0;
    logic             w_load1;
    logic             w_ferrNext;

    // The shift form keeps every register bit in use even though the MSB falls off.
    assign w_shiftIn = (r_shift << 1) | {{(WIDTH-1){1'b0}}, din};

`ifdef TDM_PARITY_EN
    logic r_par;
    logic w_parNext;
    logic r_perr;
    logic w_perrNext;
    logic w_isData;
    logic w_wordOk;

    // The parity bit is the final bit of a slot and is never shifted into the word.
    assign w_isData = (r_cnt < CW'(WIDTH));
    assign w_word   = r_shift;
    assign w_wordOk = ~(r_par ^ din);
`else
    assign w_word   = w_shiftIn;
`endif

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_shiftNext = r_shift;
        w_load0     = 1'b0;
        w_load1     = 1'b0;
        w_ferrNext  = 1'b0;
`ifdef TDM_PARITY_EN
        w_parNext   = r_par;
        w_perrNext  = 1'b0;
`endif
        if (den) begin
            if (sync) begin
                // A sync always starts a new frame; mid-frame it also drops the partial word.
                w_ferrNext  = (r_state != IDLE);
                w_stateNext = CH0;
                w_cntNext   = CW'(1);
                w_shiftNext = {{(WIDTH-1){1'b0}}, din};
`ifdef TDM_PARITY_EN
                w_parNext   = din;
`endif
            end else if (r_state != IDLE) begin
                w_cntNext = r_cnt + CW'(1);
`ifdef TDM_PARITY_EN
                w_parNext = r_par ^ din;
                if (w_isData) begin
                    w_shiftNext = w_shiftIn;
                end
`else
                w_shiftNext = w_shiftIn;
`endif
                if (r_cnt == LAST) begin
                    w_cntNext   = '0;
                    w_shiftNext = '0;
                    w_stateNext = (r_state == CH0) ? CH1 : IDLE;
`ifdef TDM_PARITY_EN
                    w_parNext   = 1'b0;
                    if (w_wordOk) begin
                        w_load0 = (r_state == CH0);
                        w_load1 = (r_state == CH1);
                    end else begin
                        w_perrNext = 1'b1;
                    end
`else
                    w_load0 = (r_state == CH0);
                    w_load1 = (r_state == CH1);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_shift <= w_shiftNext;
        end
    end

    // Words and strobes are registered together so v0/v1 coincide with the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o0   <= '0;
            r_o1   <= '0;
            r_v0   <= 1'b0;
            r_v1   <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_load0) begin
                r_o0 <= w_word;
            end
            if (w_load1) begin
                r_o1 <= w_word;
            end
            r_v0   <= w_load0;
            r_v1   <= w_load1;
            r_ferr <= w_ferrNext;
        end
    end

`ifdef TDM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_par  <= w_parNext;
            r_perr <= w_perrNext;
        end
    end

    assign perr = r_perr;
`else
    assign perr = 1'b0;
`endif

    assign o0   = r_o0;
    assign o1   = r_o1;
    assign v0   = r_v0;
    assign v1   = r_v1;
    assign ferr = r_ferr;

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed vector bench for tdm_demux2 (WIDTH=4); parity vectors are used when TDM_PARITY_EN is defined.
module tb_tdm_demux2;

    typedef struct {
        logic       s;
        logic       e;
        logic       d;
        logic [3:0] o0;
        logic [3:0] o1;
        logic       v0;
        logic       v1;
        logic       fe;
        logic       pe;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       den;
    logic       sync;
    logic [3:0] o0;
    logic [3:0] o1;
    logic       v0;
    logic       v1;
    logic       ferr;
    logic       perr;

    int   nChecks;
    int   nErrors;
    vec_t vecs[$];

    tdm_demux2 #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .den  (den),
        .sync (sync),
        .o0   (o0),
        .o1   (o1),
        .v0   (v0),
        .v1   (v1),
        .ferr (ferr),
        .perr (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(input logic s, e, d, input logic [3:0] eo0, eo1,
                                   input logic ev0, ev1, efe, epe);
        vec_t v;
        v.s = s; v.e = e; v.d = d;
        v.o0 = eo0; v.o1 = eo1;
        v.v0 = ev0; v.v1 = ev1; v.fe = efe; v.pe = epe;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eo0, eo1,
                               input logic ev0, ev1, efe, epe);
        cmp({tag, " o0"}, o0, eo0);
        cmp({tag, " o1"}, o1, eo1);
        cmp({tag, " v0"}, {3'b0, v0}, {3'b0, ev0});
        cmp({tag, " v1"}, {3'b0, v1}, {3'b0, ev1});
        cmp({tag, " ferr"}, {3'b0, ferr}, {3'b0, efe});
        cmp({tag, " perr"}, {3'b0, perr}, {3'b0, epe});
    endtask

    // Drives one bit, lets one rising edge pass, then samples 1 time unit later.
    task automatic applyStimulus(input logic s, e, d);
        sync = s;
        den  = e;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        rst_n   = 1'b0;
        sync    = 1'b0;
        den     = 1'b0;
        din     = 1'b0;

`ifndef TDM_PARITY_EN
        // basic frame 1010 / 0111, then an ignored idle bit
        addVec(1,1,1, 4'h0,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'h0,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'h0,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'hA,4'h0, 1,0,0,0);
        addVec(0,1,0, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h7, 0,1,0,0);
        addVec(0,1,1, 4'hA,4'h7, 0,0,0,0);
        // same frame with a 3-cycle stall after ch0 bit 2; sync/din during stall must be ignored
        addVec(1,1,1, 4'hA,4'h7, 0,0,0,0);
        addVec(0,1,0, 4'hA,4'h7, 0,0,0,0);
        addVec(1,0,1, 4'hA,4'h7, 0,0,0,0);
        addVec(1,0,1, 4'hA,4'h7, 0,0,0,0);
        addVec(1,0,1, 4'hA,4'h7, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h7, 0,0,0,0);
        addVec(0,1,0, 4'hA,4'h7, 1,0,0,0);
        addVec(0,1,0, 4'hA,4'h7, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h7, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h7, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h7, 0,1,0,0);
        // early sync in ch0: aborted 11, then 0011 / 1100
        addVec(1,1,1, 4'hA,4'h7, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h7, 0,0,0,0);
        addVec(1,1,0, 4'hA,4'h7, 0,0,1,0);
        addVec(0,1,0, 4'hA,4'h7, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h7, 0,0,0,0);
        addVec(0,1,1, 4'h3,4'h7, 1,0,0,0);
        addVec(0,1,1, 4'h3,4'h7, 0,0,0,0);
        addVec(0,1,1, 4'h3,4'h7, 0,0,0,0);
        addVec(0,1,0, 4'h3,4'h7, 0,0,0,0);
        addVec(0,1,0, 4'h3,4'hC, 0,1,0,0);
        // back-to-back frames 1111/0000 then 0101/1010
        addVec(1,1,1, 4'h3,4'hC, 0,0,0,0);
        addVec(0,1,1, 4'h3,4'hC, 0,0,0,0);
        addVec(0,1,1, 4'h3,4'hC, 0,0,0,0);
        addVec(0,1,1, 4'hF,4'hC, 1,0,0,0);
        addVec(0,1,0, 4'hF,4'hC, 0,0,0,0);
        addVec(0,1,0, 4'hF,4'hC, 0,0,0,0);
        addVec(0,1,0, 4'hF,4'hC, 0,0,0,0);
        addVec(0,1,0, 4'hF,4'h0, 0,1,0,0);
        addVec(1,1,0, 4'hF,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'hF,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'hF,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'h5,4'h0, 1,0,0,0);
        addVec(0,1,1, 4'h5,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'h5,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'h5,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'h5,4'hA, 0,1,0,0);
        addVec(0,0,0, 4'h5,4'hA, 0,0,0,0);
        // early sync in ch1 after 0110 loaded; restart gives 1001 / 0011
        addVec(1,1,0, 4'h5,4'hA, 0,0,0,0);
        addVec(0,1,1, 4'h5,4'hA, 0,0,0,0);
        addVec(0,1,1, 4'h5,4'hA, 0,0,0,0);
        addVec(0,1,0, 4'h6,4'hA, 1,0,0,0);
        addVec(0,1,1, 4'h6,4'hA, 0,0,0,0);
        addVec(1,1,1, 4'h6,4'hA, 0,0,1,0);
        addVec(0,1,0, 4'h6,4'hA, 0,0,0,0);
        addVec(0,1,0, 4'h6,4'hA, 0,0,0,0);
        addVec(0,1,1, 4'h9,4'hA, 1,0,0,0);
        addVec(0,1,0, 4'h9,4'hA, 0,0,0,0);
        addVec(0,1,0, 4'h9,4'hA, 0,0,0,0);
        addVec(0,1,1, 4'h9,4'hA, 0,0,0,0);
        addVec(0,1,1, 4'h9,4'h3, 0,1,0,0);
`else
        // good ch0 1010+0, bad ch1 0111+0
        addVec(1,1,1, 4'h0,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'h0,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'h0,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'h0,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'hA,4'h0, 1,0,0,0);
        addVec(0,1,0, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'hA,4'h0, 0,0,0,1);
        // good frame 0011+0 / 0111+1
        addVec(1,1,0, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'hA,4'h0, 0,0,0,0);
        addVec(0,1,0, 4'h3,4'h0, 1,0,0,0);
        addVec(0,1,0, 4'h3,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'h3,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'h3,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'h3,4'h0, 0,0,0,0);
        addVec(0,1,1, 4'h3,4'h7, 0,1,0,0);
`endif

        #12;
        checkOutput("reset", 4'h0, 4'h0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s, vecs[i].e, vecs[i].d);
            checkOutput($sformatf("vec%0d", i), vecs[i].o0, vecs[i].o1,
                        vecs[i].v0, vecs[i].v1, vecs[i].fe, vecs[i].pe);
        end

        // asynchronous reset while v1 is high and both words are nonzero
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", 4'h0, 4'h0, 0, 0, 0, 0);
        sync = 1'b0;
        den  = 1'b0;
        din  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // bits without a fresh sync must be ignored
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("noSync%0d", i), 4'h0, 4'h0, 0, 0, 0, 0);
        end

`ifndef TDM_PARITY_EN
        applyStimulus(1, 1, 1); checkOutput("fresh0", 4'h0, 4'h0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0); checkOutput("fresh1", 4'h0, 4'h0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0); checkOutput("fresh2", 4'h0, 4'h0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1); checkOutput("fresh3", 4'h9, 4'h0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0); checkOutput("fresh4", 4'h9, 4'h0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1); checkOutput("fresh5", 4'h9, 4'h0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1); checkOutput("fresh6", 4'h9, 4'h0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0); checkOutput("fresh7", 4'h9, 4'h6, 0, 1, 0, 0);
        applyStimulus(0, 0, 0); checkOutput("fresh8", 4'h9, 4'h6, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
